// File: rtl/board_mem_responder.sv
// Avalon-MM board memory for the move generators: byte squares on a 32-bit bus,
// fixed-latency pipelined reads with a bounded number of outstanding requests.
module board_mem_responder #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LATENCY = 3,
    parameter int unsigned MAX_PENDING  = 2,
    parameter logic [7:0]  FILL         = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic        slave_waitrequest,
    output logic [31:0] slave_readdata,
    output logic        slave_readdatavalid,
    output logic [15:0] write_count,
    output logic        addr_error
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(MAX_PENDING + 1);

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   init_ptr;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   pending;
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [7:0]      pipe_data [READ_LATENCY];

    logic            in_range;
    logic [AW-1:0]   addr_idx;
    logic [7:0]      rd_data;
    logic            wr_accept, rd_accept, rw_conflict;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [7:0]      mem_wdata;
    logic [23:0]     unused_writedata;

    assign unused_writedata = slave_writedata[31:8];
    assign in_range = (slave_address < 32'(DEPTH));
    assign addr_idx = slave_address[AW-1:0];
    assign rd_data  = in_range ? mem[addr_idx] : FILL;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_INIT;
        else        state <= state_next;
    end

    // Next state: leave INIT once the last square has been filled.
    always_comb begin
        state_next = state;
        if (state == S_INIT && init_ptr == AW'(DEPTH - 1))
            state_next = S_READY;
    end

    // Outputs/decode: a write always wins; a read waits only on the pending limit.
    always_comb begin
        slave_waitrequest = 1'b1;
        wr_accept         = 1'b0;
        rd_accept         = 1'b0;
        rw_conflict       = 1'b0;
        if (state == S_READY) begin
            slave_waitrequest = slave_read && !slave_write && (pending >= PW'(MAX_PENDING));
            wr_accept         = slave_write;
            rd_accept         = slave_read && !slave_write && (pending < PW'(MAX_PENDING));
            rw_conflict       = slave_read && slave_write;
        end
    end

    // Single write port shared between the INIT sweep and bus writes.
    assign mem_we    = rst_n && ((state == S_INIT) || (wr_accept && in_range));
    assign mem_addr  = (state == S_INIT) ? init_ptr : addr_idx;
    assign mem_wdata = (state == S_INIT) ? FILL : slave_writedata[7:0];

    // NOTE: the array has no reset; the INIT sweep gives it defined contents instead.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_ptr    <= '0;
            pending     <= '0;
            pipe_valid  <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe_data[i] <= '0;
            write_count <= '0;
            addr_error  <= 1'b0;
        end else begin
            if (state == S_INIT) init_ptr <= init_ptr + 1'b1;

            // Last stage is the output register, so a read issued in cycle n
            // returns in cycle n + READ_LATENCY.
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
            pipe_valid[0] <= rd_accept;
            pipe_data[0]  <= rd_accept ? rd_data : 8'h00;

            case ({rd_accept, slave_readdatavalid})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase

            if (wr_accept && in_range && write_count != 16'hFFFF)
                write_count <= write_count + 16'd1;

            if (rw_conflict || ((wr_accept || rd_accept) && !in_range))
                addr_error <= 1'b1;
        end
    end

    assign slave_readdatavalid = pipe_valid[READ_LATENCY-1];
    assign slave_readdata      = {24'd0, pipe_data[READ_LATENCY-1]};

endmodule

// File: tb/tb_board_mem_responder.sv
// Self-checking bench for board_mem_responder: a byte-array model plus per-feature
// scenario tasks, with random data and addresses drawn from $urandom.
module tb_board_mem_responder;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 3;
    localparam int unsigned MAXP  = 2;
    localparam logic [7:0]  FILL  = 8'hFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] slave_address = '0;
    logic        slave_read = 1'b0;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = '0;
    logic        slave_waitrequest;
    logic [31:0] slave_readdata;
    logic        slave_readdatavalid;
    logic [15:0] write_count;
    logic        addr_error;

    int errors = 0;
    int checks = 0;

    // Behavioural model of the board memory.
    logic [7:0] model_mem [DEPTH];
    int         model_wc;
    bit         model_err;

    board_mem_responder #(
        .DEPTH(DEPTH), .READ_LATENCY(LAT), .MAX_PENDING(MAXP), .FILL(FILL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .slave_address(slave_address),
        .slave_read(slave_read),
        .slave_write(slave_write),
        .slave_writedata(slave_writedata),
        .slave_waitrequest(slave_waitrequest),
        .slave_readdata(slave_readdata),
        .slave_readdatavalid(slave_readdatavalid),
        .write_count(write_count),
        .addr_error(addr_error)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = FILL;
        model_wc  = 0;
        model_err = 1'b0;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] wdata);
        if (addr < DEPTH) begin
            model_mem[addr] = wdata[7:0];
            if (model_wc < 65535) model_wc++;
        end else begin
            model_err = 1'b1;
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        if (addr < DEPTH) return {24'd0, model_mem[addr]};
        model_err = 1'b1;
        return {24'd0, FILL};
    endfunction

    // Bus drivers: start and end on a falling edge; they observe, never judge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata, output int waited);
        slave_address = addr; slave_writedata = wdata; slave_write = 1'b1; waited = 0;
        #1;
        while (slave_waitrequest !== 1'b0 && waited < 50) begin @(negedge clk); #1; waited++; end
        @(posedge clk);
        @(negedge clk);
        slave_write = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output int lat);
        int guard = 0;
        slave_address = addr; slave_read = 1'b1;
        #1;
        while (slave_waitrequest !== 1'b0 && guard < 50) begin @(negedge clk); #1; guard++; end
        @(posedge clk);
        @(negedge clk);
        slave_read = 1'b0;
        lat = 1;
        while (slave_readdatavalid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        data = slave_readdata;
        if (slave_readdatavalid !== 1'b1) lat = -1;
    endtask

    task automatic wait_init(output int cycles, output int valids);
        cycles = 0; valids = 0;
        while (slave_waitrequest === 1'b1 && cycles < 5000) begin
            if (slave_readdatavalid === 1'b1) valids++;
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int cycles, valids;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (slave_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_waitrequest: got %b want 1", slave_waitrequest); end
        checks++; if (slave_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", slave_readdatavalid); end
        checks++; if (slave_readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata: got %h want 0", slave_readdata); end
        checks++; if (write_count !== 16'd0) begin errors++; $display("FAIL reset_write_count: got %0d want 0", write_count); end
        checks++; if (addr_error !== 1'b0) begin errors++; $display("FAIL reset_addr_error: got %b want 0", addr_error); end
        rst_n = 1'b1;
        model_reset();
        wait_init(cycles, valids);
        checks++; if (cycles != DEPTH) begin errors++; $display("FAIL init_cycles: got %0d want %0d", cycles, DEPTH); end
    endtask

    task automatic test_fill_reads();
        logic [31:0] addrs [3] = '{32'd0, 32'd63, 32'd1023};
        logic [31:0] data, exp;
        int lat;
        foreach (addrs[i]) begin
            exp = model_read(addrs[i]);
            bus_read(addrs[i], data, lat);
            checks++; if (data !== exp) begin errors++; $display("FAIL fill_data[%0d]: got %h want %h", addrs[i], data, exp); end
            checks++; if (lat != LAT) begin errors++; $display("FAIL fill_latency[%0d]: got %0d want %0d", addrs[i], lat, LAT); end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] data, exp;
        int lat, waited;
        bus_write(32'd27, 32'hABCDEF09, waited);
        model_write(32'd27, 32'hABCDEF09);
        checks++; if (waited != 0) begin errors++; $display("FAIL write_waitrequest: got %0d wait cycles want 0", waited); end
        bus_write(32'd100, 32'h123456F7, waited);
        model_write(32'd100, 32'h123456F7);
        exp = model_read(32'd27);
        bus_read(32'd27, data, lat);
        checks++; if (data !== exp) begin errors++; $display("FAIL wr_rd_27: got %h want %h", data, exp); end
        exp = model_read(32'd100);
        bus_read(32'd100, data, lat);
        checks++; if (data !== exp) begin errors++; $display("FAIL wr_rd_100: got %h want %h", data, exp); end
        checks++; if (write_count !== 16'(model_wc)) begin errors++; $display("FAIL wr_count: got %0d want %0d", write_count, model_wc); end
        checks++; if (addr_error !== model_err) begin errors++; $display("FAIL wr_addr_error: got %b want %b", addr_error, model_err); end
    endtask

    task automatic test_rw_conflict();
        logic [31:0] wdata, data, exp;
        int lat, valids = 0;
        logic wr_seen;
        wdata = {$urandom_range(0, 32'h00FF_FFFF), 8'h00} | 32'h30;
        slave_address = 32'd5; slave_writedata = wdata; slave_read = 1'b1; slave_write = 1'b1;
        #1 wr_seen = slave_waitrequest;
        @(posedge clk);
        @(negedge clk);
        slave_read = 1'b0; slave_write = 1'b0;
        model_write(32'd5, wdata);
        model_err = 1'b1;
        checks++; if (wr_seen !== 1'b0) begin errors++; $display("FAIL rw_waitrequest: got %b want 0", wr_seen); end
        for (int i = 0; i < 2 * LAT; i++) begin
            if (slave_readdatavalid === 1'b1) valids++;
            @(negedge clk);
        end
        checks++; if (valids != 0) begin errors++; $display("FAIL rw_no_valid: got %0d pulses want 0", valids); end
        checks++; if (addr_error !== model_err) begin errors++; $display("FAIL rw_addr_error: got %b want %b", addr_error, model_err); end
        exp = model_read(32'd5);
        bus_read(32'd5, data, lat);
        checks++; if (data !== exp) begin errors++; $display("FAIL rw_mem5: got %h want %h", data, exp); end
    endtask

    task automatic apply_reset();
        int cycles, valids;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        wait_init(cycles, valids);
        checks++; if (cycles != DEPTH) begin errors++; $display("FAIL reinit_cycles: got %0d want %0d", cycles, DEPTH); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] data, exp;
        int lat, waited;
        checks++; if (addr_error !== 1'b0) begin errors++; $display("FAIL oor_err_before: got %b want 0", addr_error); end
        bus_write(32'd1024, $urandom, waited);
        model_write(32'd1024, 32'd0);
        checks++; if (write_count !== 16'(model_wc)) begin errors++; $display("FAIL oor_write_count: got %0d want %0d", write_count, model_wc); end
        checks++; if (addr_error !== model_err) begin errors++; $display("FAIL oor_err_write: got %b want %b", addr_error, model_err); end
        exp = model_read(32'd0);
        bus_read(32'd0, data, lat);
        checks++; if (data !== exp) begin errors++; $display("FAIL oor_mem0: got %h want %h", data, exp); end
        exp = model_read(32'd2000);
        bus_read(32'd2000, data, lat);
        checks++; if (data !== exp) begin errors++; $display("FAIL oor_read2000: got %h want %h", data, exp); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL oor_latency: got %0d want %0d", lat, LAT); end
        repeat (5) @(negedge clk);
        checks++; if (addr_error !== 1'b1) begin errors++; $display("FAIL oor_err_sticky: got %b want 1", addr_error); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got [$];
        int issued = 0, returned = 0, cyc = 0, first_valid = -1, third_waits = 0, max_out = 0, waited;
        logic accept;
        for (int a = 0; a < 5; a++) begin
            bus_write(32'(a), $urandom, waited);
            model_write(32'(a), {24'd0, slave_writedata[7:0]});
        end
        slave_address = 32'd0; slave_read = 1'b1;
        while (returned < 5 && cyc < 60) begin
            #1;
            if (slave_readdatavalid === 1'b1) begin
                got.push_back(slave_readdata[7:0]);
                returned++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (slave_read && issued == 2 && slave_waitrequest === 1'b1) third_waits++;
            accept = slave_read && (slave_waitrequest === 1'b0);
            if (issued + int'(accept) - returned > max_out) max_out = issued + int'(accept) - returned;
            @(posedge clk);
            if (accept) issued++;
            @(negedge clk);
            cyc++;
            if (issued < 5) slave_address = 32'(issued);
            else slave_read = 1'b0;
        end
        slave_read = 1'b0;
        checks++; if (got.size() != 5) begin errors++; $display("FAIL b2b_pulses: got %0d want 5", got.size()); end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            checks++; if (got[i] !== model_mem[i]) begin errors++; $display("FAIL b2b_order[%0d]: got %h want %h", i, got[i], model_mem[i]); end
        end
        checks++; if (first_valid != LAT) begin errors++; $display("FAIL b2b_first_valid: got cycle %0d want %0d", first_valid, LAT); end
        checks++; if (third_waits != 2) begin errors++; $display("FAIL b2b_third_wait: got %0d cycles want 2", third_waits); end
        checks++; if (max_out > MAXP) begin errors++; $display("FAIL b2b_pending: got %0d want <= %0d", max_out, MAXP); end
    endtask

    task automatic test_random();
        logic [31:0] addr, wdata, data, exp;
        int lat, waited;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       addr = DEPTH + $urandom_range(0, 5000);
                1:       addr = $urandom_range(0, 15);
                default: addr = $urandom_range(0, DEPTH - 1);
            endcase
            if ($urandom_range(0, 1) == 0) begin
                wdata = $urandom;
                bus_write(addr, wdata, waited);
                model_write(addr, wdata);
            end else begin
                exp = model_read(addr);
                bus_read(addr, data, lat);
                checks++; if (data !== exp || lat != LAT) begin
                    errors++; $display("FAIL rand_read[%0d]: got %h lat %0d want %h lat %0d", addr, data, lat, exp, LAT);
                end
            end
        end
        checks++; if (write_count !== 16'(model_wc)) begin errors++; $display("FAIL rand_write_count: got %0d want %0d", write_count, model_wc); end
        checks++; if (addr_error !== model_err) begin errors++; $display("FAIL rand_addr_error: got %b want %b", addr_error, model_err); end
    endtask

    task automatic test_reset_mid_flight();
        logic [31:0] data;
        int lat, cycles, valids, bad = 0;
        logic w0, w1;
        slave_address = $urandom_range(0, DEPTH - 1); slave_read = 1'b1;
        #1 w0 = slave_waitrequest;
        @(posedge clk);
        @(negedge clk);
        slave_address = $urandom_range(0, DEPTH - 1);
        #1 w1 = slave_waitrequest;
        @(posedge clk);
        @(negedge clk);
        slave_read = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        checks++; if (w0 !== 1'b0 || w1 !== 1'b0) begin errors++; $display("FAIL mid_accept: got %b%b want 00", w0, w1); end
        wait_init(cycles, valids);
        checks++; if (valids != 0) begin errors++; $display("FAIL mid_dropped_valid: got %0d pulses want 0", valids); end
        checks++; if (cycles != DEPTH) begin errors++; $display("FAIL mid_init_cycles: got %0d want %0d", cycles, DEPTH); end
        checks++; if (write_count !== 16'd0) begin errors++; $display("FAIL mid_write_count: got %0d want 0", write_count); end
        for (int a = 0; a < DEPTH; a++) begin
            bus_read(32'(a), data, lat);
            if (data !== model_read(32'(a)) || lat != LAT) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_all_fill: got %0d bad squares want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_fill_reads();
        test_write_read();
        test_rw_conflict();
        apply_reset();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_reset_mid_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/board_mem_responder.md
Name: board_mem_responder

Overview:
- Avalon-MM slave that serves as board memory for the move-generator masters (rook, and later the other pieces).
- The generator reads the source board and writes its generated boards through this block.
- Each square is one byte, byte-addressed, and carried in bits [7:0] of the 32-bit data bus.
- Used as an on-chip board buffer in front of the SDRAM bridge, and as the synthesizable responder in generator benches.

Parameters:
DEPTH, 1024, number of byte squares stored (power of two; the default holds 16 boards of 64 squares).
READ_LATENCY, 3, cycles from read acceptance to slave_readdatavalid; legal range 1..8.
MAX_PENDING, 2, maximum accepted reads without a returned readdatavalid; legal range 1..READ_LATENCY.
FILL, 8'hFF, value every square holds after initialisation (the "never written" marker).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
slave_address  in  32  byte address of square
slave_read  in  1  read request
slave_write  in  1  write request
slave_writedata  in  32  bits [7:0] are the square value; [31:8] are ignored
slave_waitrequest  out  1  request not accepted this cycle
slave_readdata  out  32  {24'd0, square}; valid only with slave_readdatavalid
slave_readdatavalid  out  1  one-cycle pulse per accepted read, in request order
write_count  out  16  accepted in-range writes since init, saturating at 16'hFFFF
addr_error  out  1  sticky error flag; cleared only by reset

Behaviour:
- Interface is synchronous active-low: the codebase's single clock, clk, and synchronous active-low reset, rst_n. All state changes on the rising edge of clk.
- Reset (rst_n=0 sampled at an edge):
  - slave_waitrequest=1, slave_readdatavalid=0, slave_readdata=0, write_count=0, addr_error=0.
  - Pending counter and read pipeline are cleared; FSM goes to INIT with init pointer 0.
  - Reset mid-operation discards all in-flight reads: no readdatavalid is ever produced for them.
- FSM states: INIT, READY.
- INIT:
  - Writes FILL to one square per cycle, pointer 0..DEPTH-1.
  - slave_waitrequest held at 1; requests are ignored.
  - After writing DEPTH-1, goes to READY. slave_waitrequest first reads 0 exactly DEPTH cycles after reset deasserts.
- READY, write (slave_write=1, slave_read=0):
  - Always accepted (waitrequest=0).
  - If address < DEPTH: mem[address] <= writedata[7:0], and write_count increments with saturation.
  - Otherwise the write is dropped and addr_error <= 1.
- READY, read (slave_read=1, slave_write=0):
  - Accepted iff pending < MAX_PENDING. Otherwise waitrequest=1 combinationally and the master holds.
  - On acceptance, data is captured from the array at that edge: mem[address], or FILL if address >= DEPTH, with addr_error <= 1.
  - slave_readdatavalid pulses exactly READ_LATENCY cycles after the acceptance edge.
  - A write accepted on cycle N is visible to a read accepted on cycle N+1.
- Read with write (slave_read=1 and slave_write=1):
  - Write is processed as above; the read is ignored and addr_error <= 1.
  - waitrequest follows the write rule (0).
- Pending counter:
  - +1 on an accepted read, -1 on a readdatavalid, unchanged when both happen in the same cycle.
  - Never exceeds MAX_PENDING and never underflows.
- Pipeline: a READ_LATENCY-stage shift register of {valid, data}. Returned data is strictly in request order, with at most one beat per cycle.
- Neither read nor write asserted: waitrequest=0 in READY; no state change.
- Outputs are registered except slave_waitrequest, which is combinational from FSM state, pending and slave_read.

Test Plan:
1. Reset, then hold idle: waitrequest=1 for exactly 1024 cycles, then 0. Reading addresses 0, 63 and 1023 returns 32'h000000FF, each with readdatavalid exactly 3 cycles after acceptance.
2. Write 8'h09 to addr 27 and 8'hF7 (BROOK-style value) to addr 100 with writedata 32'hABCDEF09 / 32'h123456F7, then read both back: readdata 32'h00000009 and 32'h000000F7; write_count=2.
3. Issue 5 back-to-back reads of addrs 0..4 with READ_LATENCY=3, MAX_PENDING=2:
   - third request sees waitrequest=1 until the first readdatavalid;
   - exactly 5 valid pulses, in order 0..4;
   - pending never exceeds 2.
4. Write to address 1024, then read address 2000:
   - write dropped (mem[0] still FF), write_count unchanged;
   - read returns 32'h000000FF;
   - addr_error=1 and stays 1 until reset.
5. Assert read and write together at addr 5 with data 8'h30: mem[5]=8'h30, no readdatavalid is generated, addr_error=1.
6. Accept 2 reads, then assert rst_n=0 for one cycle before any data returns: no readdatavalid for the dropped reads; INIT reruns (waitrequest=1 for 1024 cycles); all squares read back 8'hFF; write_count=0.
